// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - fetch/decode/execute control sequencer for register ALU instructions
module alu_op_sequencer #(
    parameter int RCOUNT = 16
) (
    input  logic              Clock,
    input  logic              clear,
    input  logic              Run,
    input  logic              Mem_ready,
    input  logic [31:0]       IR,
    output logic              PCout,
    output logic              Zlowout,
    output logic              Zhighout,
    output logic              MDRout,
    output logic              MARin,
    output logic              PCin,
    output logic              MDRin,
    output logic              IRin,
    output logic              Yin,
    output logic              IncPC,
    output logic              Read,
    output logic              Zin_low,
    output logic              Zin_high,
    output logic              HIin,
    output logic              LOin,
    output logic [RCOUNT-1:0] Rin,
    output logic [RCOUNT-1:0] Rout,
    output logic [3:0]        operation,
    output logic              Done,
    output logic              Fault
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_FAULT
    } state_t;

    state_t state, state_nxt;

    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    logic [3:0] op_code;
    logic       legal, is_unary, is_wide;
    logic       unused_ir;

    assign opc       = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

    // Register indices beyond RCOUNT select nothing rather than aliasing.
    function automatic logic [RCOUNT-1:0] onehot(input logic [3:0] idx);
        logic [RCOUNT-1:0] v;
        v = '0;
        for (int i = 0; i < RCOUNT; i++) begin
            if (int'(idx) == i) v[i] = 1'b1;
        end
        return v;
    endfunction

    always_comb begin
        op_code  = 4'b0000;
        legal    = 1'b1;
        is_unary = 1'b0;
        is_wide  = 1'b0;
        case (opc)
            5'b00000: op_code = 4'b1101;
            5'b00001: op_code = 4'b1110;
            5'b00010: op_code = 4'b1010;
            5'b00011: op_code = 4'b1011;
            5'b00100: op_code = 4'b0101;
            5'b00101: op_code = 4'b0110;
            5'b00110: op_code = 4'b0111;
            5'b00111: op_code = 4'b1000;
            5'b01111: begin op_code = 4'b0011; is_wide  = 1'b1; end
            5'b10000: begin op_code = 4'b0100; is_wide  = 1'b1; end
            5'b10001: begin op_code = 4'b0001; is_unary = 1'b1; end
            5'b10010: begin op_code = 4'b0010; is_unary = 1'b1; end
            default:  legal = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        MDRout    = 1'b0;
        MARin     = 1'b0;
        PCin      = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        Zin_low   = 1'b0;
        Zin_high  = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        Rin       = '0;
        Rout      = '0;
        operation = 4'b0000;
        Done      = 1'b0;
        Fault     = 1'b0;
        case (state)
            S_IDLE: if (Run) state_nxt = S_T0;
            S_T0: begin
                PCout     = 1'b1;
                MARin     = 1'b1;
                IncPC     = 1'b1;
                Zin_low   = 1'b1;
                state_nxt = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (Mem_ready) state_nxt = S_T2;
            end
            S_T2: begin
                MDRout    = 1'b1;
                IRin      = 1'b1;
                state_nxt = S_T3;
            end
            S_T3: begin
                // An illegal opcode leaves the bus idle and parks in FAULT.
                if (!legal) begin
                    state_nxt = S_FAULT;
                end else begin
                    Rout      = onehot(rb);
                    Yin       = 1'b1;
                    state_nxt = S_T4;
                end
            end
            S_T4: begin
                operation = op_code;
                Zin_low   = 1'b1;
                Zin_high  = is_wide;
                Rout      = is_unary ? onehot(rb) : onehot(rc);
                state_nxt = S_T5;
            end
            S_T5: begin
                operation = op_code;
                Zlowout   = 1'b1;
                if (is_wide) begin
                    LOin      = 1'b1;
                    state_nxt = S_T6;
                end else begin
                    Rin       = onehot(ra);
                    Done      = 1'b1;
                    state_nxt = Run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                operation = op_code;
                Zhighout  = 1'b1;
                HIin      = 1'b1;
                Done      = 1'b1;
                state_nxt = Run ? S_T0 : S_IDLE;
            end
            S_FAULT: Fault = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed-vector bench for alu_op_sequencer
module tb_alu_op_sequencer;

    logic        Clock = 1'b0;
    logic        clear, Run, Mem_ready;
    logic [31:0] IR;
    logic        PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
    logic        Zin_low, Zin_high, HIin, LOin, Done, Fault;
    logic [15:0] Rin, Rout;
    logic [3:0]  operation;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    localparam logic [16:0] S_PCOUT  = 17'h10000, S_ZLOWOUT = 17'h08000, S_ZHIGHOUT = 17'h04000,
                            S_MDROUT = 17'h02000, S_MARIN   = 17'h01000, S_PCIN     = 17'h00800,
                            S_MDRIN  = 17'h00400, S_IRIN    = 17'h00200, S_YIN      = 17'h00100,
                            S_INCPC  = 17'h00080, S_READ    = 17'h00040, S_ZINLOW   = 17'h00020,
                            S_ZINHIGH= 17'h00010, S_HIIN    = 17'h00008, S_LOIN     = 17'h00004,
                            S_DONE   = 17'h00002, S_FAULT   = 17'h00001;

    logic [16:0] strobes;
    assign strobes = {PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin,
                      IncPC, Read, Zin_low, Zin_high, HIin, LOin, Done, Fault};

    alu_op_sequencer #(.RCOUNT(16)) dut (
        .Clock(Clock), .clear(clear), .Run(Run), .Mem_ready(Mem_ready), .IR(IR),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .IncPC(IncPC), .Read(Read), .Zin_low(Zin_low), .Zin_high(Zin_high),
        .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout), .operation(operation),
        .Done(Done), .Fault(Fault)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_outputs(input string tag, input logic [16:0] s, input logic [15:0] rin,
                               input logic [15:0] rout, input logic [3:0] op);
        check({tag, ".strobes"}, 32'(strobes), 32'(s));
        check({tag, ".Rin"}, 32'(Rin), 32'(rin));
        check({tag, ".Rout"}, 32'(Rout), 32'(rout));
        check({tag, ".op"}, 32'(operation), 32'(op));
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    // Entered with the DUT in IDLE or in the final step of a previous instruction.
    task automatic run_instr(input string tag, input logic [31:0] ir, input int nwait,
                             input logic wide, input logic [15:0] rout3, input logic [15:0] rout4,
                             input logic [15:0] rin5, input logic [3:0] op,
                             input logic run_next, input int done_cyc);
        IR        = ir;
        Run       = 1'b1;
        Mem_ready = 1'b1;
        cyc       = 0;
        tick();
        exp_outputs({tag, ".T0"}, S_PCOUT | S_MARIN | S_INCPC | S_ZINLOW, 16'h0, 16'h0, 4'h0);
        Run = run_next;
        tick();
        for (int i = 0; i <= nwait; i++) begin
            Mem_ready = (i == nwait);
            exp_outputs({tag, ".T1"}, S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN, 16'h0, 16'h0, 4'h0);
            tick();
        end
        Mem_ready = 1'b1;
        exp_outputs({tag, ".T2"}, S_MDROUT | S_IRIN, 16'h0, 16'h0, 4'h0);
        tick();
        exp_outputs({tag, ".T3"}, S_YIN, 16'h0, rout3, 4'h0);
        tick();
        exp_outputs({tag, ".T4"}, S_ZINLOW | (wide ? S_ZINHIGH : 17'h0), 16'h0, rout4, op);
        tick();
        if (!wide) begin
            exp_outputs({tag, ".T5"}, S_ZLOWOUT | S_DONE, rin5, 16'h0, op);
        end else begin
            exp_outputs({tag, ".T5"}, S_ZLOWOUT | S_LOIN, 16'h0, 16'h0, op);
            tick();
            exp_outputs({tag, ".T6"}, S_ZHIGHOUT | S_HIIN | S_DONE, 16'h0, 16'h0, op);
        end
        check({tag, ".done_cycle"}, 32'(cyc), 32'(done_cyc));
    endtask

    initial begin
        clear     = 1'b1;
        Run       = 1'b0;
        Mem_ready = 1'b1;
        IR        = 32'h0;
        tick();
        tick();
        exp_outputs("reset", 17'h0, 16'h0, 16'h0, 4'h0);
        clear = 1'b0;
        tick();
        exp_outputs("idle", 17'h0, 16'h0, 16'h0, 4'h0);

        run_instr("add", 32'h00918000, 0, 1'b0, 16'h0004, 16'h0008, 16'h0002, 4'b1101, 1'b0, 6);
        tick();
        exp_outputs("add.after", 17'h0, 16'h0, 16'h0, 4'h0);

        run_instr("add_wait", 32'h00918000, 3, 1'b0, 16'h0004, 16'h0008, 16'h0002, 4'b1101, 1'b0, 9);
        tick();
        exp_outputs("add_wait.after", 17'h0, 16'h0, 16'h0, 4'h0);

        run_instr("mul", 32'h7A300000, 0, 1'b1, 16'h0040, 16'h0001, 16'h0000, 4'b0011, 1'b0, 7);
        tick();
        exp_outputs("mul.after", 17'h0, 16'h0, 16'h0, 4'h0);

        run_instr("neg", 32'h8A300000, 0, 1'b0, 16'h0040, 16'h0040, 16'h0010, 4'b0001, 1'b0, 6);
        tick();
        exp_outputs("neg.after", 17'h0, 16'h0, 16'h0, 4'h0);

        run_instr("b2b_1", 32'h00918000, 0, 1'b0, 16'h0004, 16'h0008, 16'h0002, 4'b1101, 1'b1, 6);
        run_instr("b2b_2", 32'h00918000, 0, 1'b0, 16'h0004, 16'h0008, 16'h0002, 4'b1101, 1'b0, 6);
        tick();
        exp_outputs("b2b.after", 17'h0, 16'h0, 16'h0, 4'h0);

        IR  = 32'hF8000000;
        Run = 1'b1;
        tick();
        Run = 1'b0;
        tick();
        tick();
        tick();
        exp_outputs("illegal.T3", 17'h0, 16'h0, 16'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_outputs("fault", S_FAULT, 16'h0, 16'h0, 4'h0);
            Run = ~Run;
        end
        Run = 1'b0;
        #2 clear = 1'b1;
        #1 exp_outputs("fault.clear", 17'h0, 16'h0, 16'h0, 4'h0);
        tick();
        clear = 1'b0;
        tick();
        exp_outputs("fault.idle", 17'h0, 16'h0, 16'h0, 4'h0);

        IR  = 32'h00918000;
        Run = 1'b1;
        tick();
        Run = 1'b0;
        tick();
        tick();
        tick();
        tick();
        exp_outputs("abort.T4", S_ZINLOW, 16'h0, 16'h0008, 4'b1101);
        #2 clear = 1'b1;
        #1 exp_outputs("abort.async", 17'h0, 16'h0, 16'h0, 4'h0);
        tick();
        exp_outputs("abort.held", 17'h0, 16'h0, 16'h0, 4'h0);
        clear = 1'b0;
        tick();
        exp_outputs("abort.idle", 17'h0, 16'h0, 16'h0, 4'h0);

        run_instr("post_abort", 32'h00918000, 0, 1'b0, 16'h0004, 16'h0008, 16'h0002, 4'b1101, 1'b0, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
